pipelined_barrel_shifter: RTL and testbench



---
 rtl/pipelined_barrel_shifter.sv | 184 ++++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Multifunction barrel shifter: rotate/shift a WIDTH-bit operand by a run-time
//   amount through AW = log2(WIDTH) registered stages. Stage k applies a 2^k
//   step when amount bit k is set. Valid/ready handshakes on both sides, and
//   bubbles collapse because an empty stage always accepts.
//
//   Ports
//     clk, reset_n             clock, async active-low reset
//     in_valid/in_ready        request handshake
//     in_data  [WIDTH-1:0]     operand
//     in_amt   [AW-1:0]        amount 0..WIDTH-1
//     in_op    [2:0]           000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA
//     out_valid/out_ready      result handshake
//     out_data [WIDTH-1:0]     result
//     out_illegal              op code was illegal; data returned unshifted
//
//   Build option: define BARREL_SHIFTER_SRA_EN to make op 100 an arithmetic
//   right shift. Without it op 100 is illegal and no sign-fill logic exists.

// One pipeline stage: fixed 2^K step, selected by bit K of the carried amount.
module pbs_stage #(
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [AW-1:0]    up_amt,
  input  logic [2:0]       up_op,
  input  logic             up_ill,
`ifdef BARREL_SHIFTER_SRA_EN
  input  logic             up_sign,
  output logic             sign,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [AW-1:0]    amt,
  output logic [2:0]       op,
  output logic             ill
);
  localparam int S = 1 << K;
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
`ifdef BARREL_SHIFTER_SRA_EN
  localparam logic [2:0] OP_SRA = 3'b100;
`endif

  logic [WIDTH-1:0] sll, srl, rol, ror, shf;
  assign sll = up_data << S;
  assign srl = up_data >> S;
  assign rol = sll | (up_data >> (WIDTH - S));
  assign ror = srl | (up_data << (WIDTH - S));
`ifdef BARREL_SHIFTER_SRA_EN
  // Sign comes from the original operand's MSB, carried alongside the data,
  // so each stage fills with it regardless of what earlier stages did.
  logic [WIDTH-1:0] sra;
  assign sra = srl | (up_sign ? ~({WIDTH{1'b1}} >> S) : '0);
`endif

  always_comb begin
    shf = up_data;
    if (up_amt[K]) begin
      case (up_op)
        OP_ROL:  shf = rol;
        OP_ROR:  shf = ror;
        OP_SLL:  shf = sll;
        OP_SRL:  shf = srl;
`ifdef BARREL_SHIFTER_SRA_EN
        OP_SRA:  shf = sra;
`endif
        default: shf = up_data;
      endcase
    end
  end

  // Payload only moves with a real item, so a drained pipe keeps its last result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      op    <= '0;
      ill   <= 1'b0;
`ifdef BARREL_SHIFTER_SRA_EN
      sign  <= 1'b0;
`endif
    end else if (ld) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= shf;
        amt  <= up_amt;
        op   <= up_op;
        ill  <= up_ill;
`ifdef BARREL_SHIFTER_SRA_EN
        sign <= up_sign;
`endif
      end
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_illegal
);
  // Index 0 is the input side, index k+1 is the register set of stage k.
  logic [AW:0]            vld_pipe;
  logic [AW:0][WIDTH-1:0] dat_pipe;
  logic [AW:0][AW-1:0]    amt_pipe;
  logic [AW:0][2:0]       op_pipe;
  logic [AW:0]            ill_pipe;
  logic [AW:0]            rdy;
`ifdef BARREL_SHIFTER_SRA_EN
  logic [AW:0]            sgn_pipe;
`endif

  logic legal;
`ifdef BARREL_SHIFTER_SRA_EN
  assign legal = (in_op <= 3'd4);
`else
  assign legal = (in_op <= 3'd3);
`endif

  // Illegal ops travel with amount 0, so every stage passes the data through.
  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = in_data;
  assign amt_pipe[0] = legal ? in_amt : '0;
  assign op_pipe[0]  = in_op;
  assign ill_pipe[0] = ~legal;
`ifdef BARREL_SHIFTER_SRA_EN
  assign sgn_pipe[0] = in_data[WIDTH-1];
`endif

  assign rdy[AW]  = out_ready;
  assign in_ready = rdy[0];

  genvar k;
  generate
    for (k = 0; k < AW; k++) begin : g_stage
      assign rdy[k] = ~vld_pipe[k+1] | rdy[k+1];

      pbs_stage #(.WIDTH(WIDTH), .AW(AW), .K(k)) u_stage (
        .clk      (clk),
        .reset_n  (reset_n),
        .ld       (rdy[k]),
        .up_valid (vld_pipe[k]),
        .up_data  (dat_pipe[k]),
        .up_amt   (amt_pipe[k]),
        .up_op    (op_pipe[k]),
        .up_ill   (ill_pipe[k]),
`ifdef BARREL_SHIFTER_SRA_EN
        .up_sign  (sgn_pipe[k]),
        .sign     (sgn_pipe[k+1]),
`endif
        .valid    (vld_pipe[k+1]),
        .data     (dat_pipe[k+1]),
        .amt      (amt_pipe[k+1]),
        .op       (op_pipe[k+1]),
        .ill      (ill_pipe[k+1])
      );
    end
  endgenerate

  assign out_valid   = vld_pipe[AW];
  assign out_data    = dat_pipe[AW];
  assign out_illegal = ill_pipe[AW];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: an 8-bit instance carries the
// main directed vectors, a 32-bit instance covers the wide build.
module tb_pipelined_barrel_shifter;
  localparam int AW8  = 3;
  localparam int AW32 = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // 8-bit DUT
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_illegal;
  logic [7:0] in_data = '0, out_data;
  logic [2:0] in_amt = '0, in_op = '0;

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_illegal(out_illegal));

  // 32-bit DUT
  logic        v32 = 1'b0, r32, ov32, or32 = 1'b1, oil32;
  logic [31:0] d32 = '0, od32;
  logic [4:0]  a32 = '0;
  logic [2:0]  op32 = '0;

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v32), .in_ready(r32), .in_data(d32),
    .in_amt(a32), .in_op(op32),
    .out_valid(ov32), .out_ready(or32),
    .out_data(od32), .out_illegal(oil32));

  typedef struct {
    logic [31:0] d;
    logic        ill;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t q32[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, expv);
  endtask

  // Present one item, wait (bounded) for acceptance, log the expectation.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] op,
                      input logic [7:0] ed, input logic eil, input bit lat, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
    end else begin
      e.d = {24'h0, ed}; e.ill = eil; e.lat = lat; e.acc = cyc + 1;
      if (push) q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Monitors: compare on every output transfer.
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out8: got data %0h with nothing expected", out_data);
      end else begin
        e = q.pop_front();
        chk("out8_data", {56'h0, out_data}, {32'h0, e.d});
        chk("out8_illegal", {63'h0, out_illegal}, {63'h0, e.ill});
        if (e.lat) chk("out8_latency", 64'(cyc - e.acc), 64'(AW8 - 1));
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clk); #2;
    if (reset_n && ov32 && or32) begin
      if (q32.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out32: got data %0h with nothing expected", od32);
      end else begin
        e = q32.pop_front();
        chk("out32_data", {32'h0, od32}, {32'h0, e.d});
        chk("out32_illegal", {63'h0, oil32}, {63'h0, e.ill});
        if (e.lat) chk("out32_latency", 64'(cyc - e.acc), 64'(AW32 - 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_data", {56'h0, out_data}, 64'h0);
    chk("rst_out_illegal", {63'h0, out_illegal}, 64'h0);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Basic ops on 0x96, amount 3
    send(8'h96, 3'd3, 3'b000, 8'hB4, 1'b0, 1'b1, 1'b1);
    send(8'h96, 3'd3, 3'b001, 8'hD2, 1'b0, 1'b1, 1'b1);
    send(8'h96, 3'd3, 3'b010, 8'hB0, 1'b0, 1'b1, 1'b1);
    send(8'h96, 3'd3, 3'b011, 8'h12, 1'b0, 1'b1, 1'b1);
`ifdef BARREL_SHIFTER_SRA_EN
    send(8'h96, 3'd3, 3'b100, 8'hF2, 1'b0, 1'b1, 1'b1);
`else
    send(8'h96, 3'd3, 3'b100, 8'h96, 1'b1, 1'b1, 1'b1);
`endif
    send(8'h96, 3'd3, 3'b111, 8'h96, 1'b1, 1'b1, 1'b1);
    send(8'hA5, 3'd0, 3'b001, 8'hA5, 1'b0, 1'b1, 1'b1);

    // Back-to-back ROL stream of 0x01, amount 0..7
    for (int i = 0; i < 8; i++)
      send(8'h01, 3'(i), 3'b000, 8'(1 << i), 1'b0, 1'b1, 1'b1);

    // Stall: capacity is exactly AW items, output held stable
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    send(8'h01, 3'd1, 3'b000, 8'h02, 1'b0, 1'b0, 1'b1);
    send(8'h01, 3'd2, 3'b000, 8'h04, 1'b0, 1'b0, 1'b1);
    send(8'h01, 3'd3, 3'b000, 8'h08, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("full_in_ready", {63'h0, in_ready}, 64'h0);
    chk("full_out_valid", {63'h0, out_valid}, 64'h1);
    chk("stall_data_a", {56'h0, out_data}, 64'h02);
    repeat (3) @(negedge clk);
    #1 chk("stall_data_b", {56'h0, out_data}, 64'h02);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("drain_in_ready", {63'h0, in_ready}, 64'h1);

    // Async reset with two items in flight; they must never emerge
    repeat (6) @(negedge clk);
    send(8'h11, 3'd1, 3'b000, 8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 3'd1, 3'b000, 8'h66, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("async_rst_data", {56'h0, out_data}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 32-bit build
    @(negedge clk);
    v32 = 1'b1; d32 = 32'h8000_0001; a32 = 5'd1; op32 = 3'b001;
    e.d = 32'hC000_0000; e.ill = 1'b0; e.lat = 1'b1; e.acc = cyc + 1;
    q32.push_back(e);
    @(negedge clk);
    d32 = 32'h8000_0000; a32 = 5'd31; op32 = 3'b100;
`ifdef BARREL_SHIFTER_SRA_EN
    e.d = 32'hFFFF_FFFF; e.ill = 1'b0;
`else
    e.d = 32'h8000_0000; e.ill = 1'b1;
`endif
    e.lat = 1'b1; e.acc = cyc + 1;
    q32.push_back(e);
    @(negedge clk);
    v32 = 1'b0;

    n = 0;
    while ((q.size() != 0 || q32.size() != 0) && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("queues_empty", 64'(q.size() + q32.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
